// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALU op codes, register-zero
// constant and the packed decoded-control bundle carried down the pipeline.
package mips_pkg;

   localparam int ALUOP_W = 3;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [ALUOP_W-1:0] {
      ALUOP_ADD   = 3'd0,
      ALUOP_SUB   = 3'd1,
      ALUOP_RTYPE = 3'd2,
      ALUOP_AND   = 3'd3,
      ALUOP_OR    = 3'd4,
      ALUOP_SLT   = 3'd5,
      ALUOP_LUI   = 3'd6,
      ALUOP_XOR   = 3'd7
   } aluop_e;

   // Single-bit control flags; aluop travels separately so its width can be
   // parameterised per instance.
   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic alusrc;
      logic regdst;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   // An empty ID slot must never carry live control into EX.
   function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
      return valid ? c : CTRL_NOP;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: an ID instruction reading the register that the
// load sitting in EX is about to write must wait one cycle.
module hazard_detect
   import mips_pkg::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_valid,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   output logic       hazard
);

   logic rs_match;
   logic rt_match;
   logic load_in_ex;

   always_comb begin
      rs_match   = (ex_rt == id_rs);
      rt_match   = id_uses_rt & (ex_rt == id_rt);
      // $0 is hard-wired, so a load targeting it never produces a value to wait for.
      load_in_ex = ex_valid & ex_memread & (ex_rt != REG_ZERO);
      hazard     = id_valid & load_in_ex & (rs_match | rt_match);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating count of inserted bubbles.
module id_ex_stage #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = mips_pkg::ALUOP_W,
   parameter int CNT_W   = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic [4:0]         id_rd,
   input  logic               id_uses_rt,
   input  logic [DATA_W-1:0]  id_readdata1,
   input  logic [DATA_W-1:0]  id_readdata2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_memtoreg,
   input  logic               id_alusrc,
   input  logic               id_regdst,
   input  logic [ALUOP_W-1:0] id_aluop,
   input  logic               flush,
   input  logic               ex_hold,
   output logic               stall_out,
   output logic               ex_valid,
   output logic [4:0]         ex_rs,
   output logic [4:0]         ex_rt,
   output logic [4:0]         ex_rd,
   output logic [DATA_W-1:0]  ex_readdata1,
   output logic [DATA_W-1:0]  ex_readdata2,
   output logic [DATA_W-1:0]  ex_imm,
   output logic               ex_regwrite,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_memtoreg,
   output logic               ex_alusrc,
   output logic               ex_regdst,
   output logic [ALUOP_W-1:0] ex_aluop,
   output logic [CNT_W-1:0]   stall_cnt
);
   import mips_pkg::*;

   // Handshake: id_valid marks a real instruction in ID; it is consumed on a
   // rising edge only when stall_out=0. ex_hold=1 freezes EX and makes the
   // upstream hold (stall_out=1), so ID contents must stay put while held.

   typedef enum logic [1:0] {
      UPD_LOAD,
      UPD_HOLD,
      UPD_FLUSH,
      UPD_BUBBLE
   } upd_e;

   upd_e               upd;
   logic               hazard;
   ctrl_t              id_ctrl;

   logic               valid_q,  valid_d;
   logic [4:0]         rs_q,     rs_d;
   logic [4:0]         rt_q,     rt_d;
   logic [4:0]         rd_q,     rd_d;
   logic [DATA_W-1:0]  rdata1_q, rdata1_d;
   logic [DATA_W-1:0]  rdata2_q, rdata2_d;
   logic [DATA_W-1:0]  imm_q,    imm_d;
   ctrl_t              ctrl_q,   ctrl_d;
   logic [ALUOP_W-1:0] aluop_q,  aluop_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;

   assign id_ctrl = {id_regwrite, id_memread, id_memwrite,
                     id_memtoreg, id_alusrc, id_regdst};

   hazard_detect u_hazard (
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .ex_valid   (valid_q),
      .ex_memread (ctrl_q.memread),
      .ex_rt      (rt_q),
      .hazard     (hazard)
   );

   // A flush clears IF/ID anyway, so a hazard alone need not hold the front end.
   assign stall_out = ex_hold | (hazard & ~flush);

   always_comb begin
      upd = UPD_LOAD;
      if (ex_hold) begin
         upd = UPD_HOLD;
      end else if (flush) begin
         upd = UPD_FLUSH;
      end else if (hazard) begin
         upd = UPD_BUBBLE;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      imm_d    = imm_q;
      ctrl_d   = ctrl_q;
      aluop_d  = aluop_q;
      cnt_d    = cnt_q;
      case (upd)
         UPD_HOLD: begin
         end
         UPD_FLUSH, UPD_BUBBLE: begin
            valid_d  = 1'b0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            rdata1_d = '0;
            rdata2_d = '0;
            imm_d    = '0;
            ctrl_d   = CTRL_NOP;
            aluop_d  = '0;
            if (upd == UPD_BUBBLE && cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            valid_d  = id_valid;
            rs_d     = id_rs;
            rt_d     = id_rt;
            rd_d     = id_rd;
            rdata1_d = id_readdata1;
            rdata2_d = id_readdata2;
            imm_d    = id_imm;
            ctrl_d   = gate_ctrl(id_ctrl, id_valid);
            aluop_d  = id_valid ? id_aluop : '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q  <= 1'b0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         rdata1_q <= '0;
         rdata2_q <= '0;
         imm_q    <= '0;
         ctrl_q   <= CTRL_NOP;
         aluop_q  <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
         imm_q    <= imm_d;
         ctrl_q   <= ctrl_d;
         aluop_q  <= aluop_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_rd        = rd_q;
   assign ex_readdata1 = rdata1_q;
   assign ex_readdata2 = rdata2_q;
   assign ex_imm       = imm_q;
   assign ex_regwrite  = ctrl_q.regwrite;
   assign ex_memread   = ctrl_q.memread;
   assign ex_memwrite  = ctrl_q.memwrite;
   assign ex_memtoreg  = ctrl_q.memtoreg;
   assign ex_alusrc    = ctrl_q.alusrc;
   assign ex_regdst    = ctrl_q.regdst;
   assign ex_aluop     = aluop_q;
   assign stall_cnt    = cnt_q;

endmodule
